// File: rtl/ix_scoreboard.sv
// Issue-stage register scoreboard: per-register pending-write counters plus the
// writeback port of the newest producer, queried combinationally by issue.
module ix_scoreboard #(
  parameter int NREG = 32,
  parameter int NSRC = 2,
  parameter int NWB  = 2,
  parameter int CNTW = 2,
  localparam int RW  = $clog2(NREG),
  localparam int PW  = (NWB > 1) ? $clog2(NWB) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                iss_valid,
  input  logic                iss_wb_en,
  input  logic [RW-1:0]       iss_dst,
  input  logic [PW-1:0]       iss_pipe,
  output logic                iss_ready,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*RW-1:0]   wb_dst,
  input  logic [NSRC*RW-1:0]  src,
  output logic [NSRC-1:0]     src_busy,
  output logic [NSRC*PW-1:0]  src_pipe,
  output logic                busy_any,
  output logic                err
);

  // Wide enough to hold cnt + 1 and the sum of all same-cycle writeback hits.
  localparam int SW = CNTW + $clog2(NWB + 1) + 1;

  logic [CNTW-1:0] cnt_q  [NREG];
  logic [CNTW-1:0] cnt_d  [NREG];
  logic [PW-1:0]   pipe_q [NREG];
  logic [PW-1:0]   pipe_d [NREG];
  logic            err_q, err_d;
  logic            acc;
  logic            uflow;
  logic [SW-1:0]   avail;
  logic [SW-1:0]   dec;

  function automatic logic [SW-1:0] hits_of(input logic [RW-1:0]     r,
                                            input logic [NWB-1:0]    v,
                                            input logic [NWB*RW-1:0] d);
    hits_of = '0;
    for (int p = 0; p < NWB; p++)
      if (v[p] && (d[p*RW +: RW] == r) && (r != '0))
        hits_of = hits_of + SW'(1);
  endfunction

  assign iss_ready = !(iss_wb_en && (iss_dst != '0) && (cnt_q[iss_dst] == {CNTW{1'b1}}));
  assign acc       = iss_valid && iss_ready && iss_wb_en && (iss_dst != '0);
  assign err       = err_q;

  always_comb begin
    cnt_d  = cnt_q;
    pipe_d = pipe_q;
    uflow  = 1'b0;
    avail  = '0;
    dec    = '0;
    for (int r = 1; r < NREG; r++) begin
      avail = SW'(cnt_q[r]) + SW'(acc && (iss_dst == RW'(r)));
      dec   = hits_of(RW'(r), wb_valid, wb_dst);
      if (dec > avail) begin
        cnt_d[r] = '0;
        uflow    = 1'b1;
      end else begin
        cnt_d[r] = CNTW'(avail - dec);
      end
    end
    if (acc)
      pipe_d[iss_dst] = iss_pipe;
    // Clear wins over everything in flight this cycle, including error reporting.
    if (clear) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_d[r]  = '0;
        pipe_d[r] = '0;
      end
    end
    cnt_d[0]  = '0;
    pipe_d[0] = '0;
    err_d     = err_q | (uflow && !clear);
  end

  always_comb begin
    src_busy = '0;
    src_pipe = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_busy[i] = (src[i*RW +: RW] != '0) &&
                    (SW'(cnt_q[src[i*RW +: RW]]) > hits_of(src[i*RW +: RW], wb_valid, wb_dst));
      src_pipe[i*PW +: PW] = pipe_q[src[i*RW +: RW]];
    end
  end

  always_comb begin
    busy_any = 1'b0;
    for (int r = 1; r < NREG; r++)
      busy_any = busy_any | (cnt_q[r] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r]  <= '0;
        pipe_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pipe_q <= pipe_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_ix_scoreboard.sv
// Directed bench for ix_scoreboard: one task per scenario, hand-computed expectations.
module tb_ix_scoreboard;
  localparam int NREG = 32;
  localparam int NSRC = 2;
  localparam int NWB  = 2;
  localparam int CNTW = 2;
  localparam int RW   = 5;
  localparam int PW   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, clear, iss_valid, iss_wb_en, iss_ready, busy_any, err;
  logic [RW-1:0]       iss_dst;
  logic [PW-1:0]       iss_pipe;
  logic [NWB-1:0]      wb_valid;
  logic [NWB*RW-1:0]   wb_dst;
  logic [NSRC*RW-1:0]  src;
  logic [NSRC-1:0]     src_busy;
  logic [NSRC*PW-1:0]  src_pipe;

  int checks = 0;
  int errors = 0;

  ix_scoreboard #(.NREG(NREG), .NSRC(NSRC), .NWB(NWB), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .iss_valid(iss_valid), .iss_wb_en(iss_wb_en),
    .iss_dst(iss_dst), .iss_pipe(iss_pipe), .iss_ready(iss_ready), .wb_valid(wb_valid),
    .wb_dst(wb_dst), .src(src), .src_busy(src_busy), .src_pipe(src_pipe),
    .busy_any(busy_any), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_wb_en = 1'b0; iss_dst = '0; iss_pipe = '0;
    wb_valid = '0; wb_dst = '0; clear = 1'b0;
  endtask

  task automatic issue(input logic [RW-1:0] d, input logic [PW-1:0] p);
    iss_valid = 1'b1; iss_wb_en = 1'b1; iss_dst = d; iss_pipe = p;
    tick();
    idle();
  endtask

  task automatic test_reset();
    iss_wb_en = 1'b1; iss_dst = 5'd5; src = {5'd3, 5'd5};
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", iss_ready); end
    checks++; if (src_busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", src_busy); end
    checks++; if (src_pipe !== 2'b00) begin errors++; $display("FAIL reset_pipe got %b exp 00", src_pipe); end
    checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL reset_busy_any got %b exp 0", busy_any); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    idle();
  endtask

  task automatic test_issue_wb();
    issue(5'd5, 1'b1);
    src = {5'd0, 5'd5};
    #1;
    checks++; if (src_busy !== 2'b01) begin errors++; $display("FAIL iw_busy got %b exp 01", src_busy); end
    checks++; if (src_pipe !== 2'b01) begin errors++; $display("FAIL iw_pipe got %b exp 01", src_pipe); end
    checks++; if (busy_any !== 1'b1) begin errors++; $display("FAIL iw_busy_any got %b exp 1", busy_any); end
    wb_valid = 2'b10; wb_dst = {5'd5, 5'd0};
    #1;
    checks++; if (src_busy !== 2'b00) begin errors++; $display("FAIL iw_fwd_busy got %b exp 00", src_busy); end
    checks++; if (busy_any !== 1'b1) begin errors++; $display("FAIL iw_fwd_busy_any got %b exp 1", busy_any); end
    tick(); idle(); #1;
    checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL iw_drain_busy_any got %b exp 0", busy_any); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL iw_err got %b exp 0", err); end
  endtask

  task automatic test_saturate();
    issue(5'd3, 1'b0); issue(5'd3, 1'b0); issue(5'd3, 1'b1);
    iss_wb_en = 1'b1; iss_dst = 5'd3; #1;
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sat_ready3 got %b exp 0", iss_ready); end
    iss_dst = 5'd4; #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_ready4 got %b exp 1", iss_ready); end
    // Same-cycle writeback does not relieve saturation; this issue is refused.
    iss_valid = 1'b1; iss_dst = 5'd3; wb_valid = 2'b01; wb_dst = {5'd0, 5'd3}; #1;
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sat_ready_wb got %b exp 0", iss_ready); end
    tick(); idle();
    iss_wb_en = 1'b1; iss_dst = 5'd3; #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_ready_after got %b exp 1", iss_ready); end
    idle();
    wb_valid = 2'b11; wb_dst = {5'd3, 5'd3};
    tick(); idle(); #1;
    checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL sat_drain got %b exp 0", busy_any); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sat_err got %b exp 0", err); end
  endtask

  task automatic test_same_cycle();
    issue(5'd7, 1'b0);
    iss_valid = 1'b1; iss_wb_en = 1'b1; iss_dst = 5'd7; iss_pipe = 1'b1;
    wb_valid = 2'b01; wb_dst = {5'd0, 5'd7}; src = {5'd7, 5'd0};
    #1;
    checks++; if (src_busy !== 2'b00) begin errors++; $display("FAIL sc_busy_now got %b exp 00", src_busy); end
    tick(); idle(); #1;
    checks++; if (src_busy !== 2'b10) begin errors++; $display("FAIL sc_busy_next got %b exp 10", src_busy); end
    checks++; if (src_pipe !== 2'b10) begin errors++; $display("FAIL sc_pipe got %b exp 10", src_pipe); end
    wb_valid = 2'b10; wb_dst = {5'd7, 5'd0};
    tick(); idle(); #1;
    checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL sc_drain got %b exp 0", busy_any); end
    checks++; if (src_pipe !== 2'b10) begin errors++; $display("FAIL sc_pipe_kept got %b exp 10", src_pipe); end
  endtask

  task automatic test_dual_wb();
    issue(5'd9, 1'b0); issue(5'd9, 1'b0);
    src = {5'd0, 5'd9}; #1;
    checks++; if (src_busy !== 2'b01) begin errors++; $display("FAIL dual_busy_pre got %b exp 01", src_busy); end
    wb_valid = 2'b11; wb_dst = {5'd9, 5'd9}; #1;
    checks++; if (src_busy !== 2'b00) begin errors++; $display("FAIL dual_busy got %b exp 00", src_busy); end
    tick(); idle(); #1;
    checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL dual_busy_any got %b exp 0", busy_any); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL dual_err got %b exp 0", err); end
  endtask

  task automatic test_err();
    wb_valid = 2'b01; wb_dst = {5'd0, 5'd12};
    tick(); idle(); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
    tick(); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
    clear = 1'b1; wb_valid = 2'b10; wb_dst = {5'd0, 5'd0};
    tick(); idle(); src = {5'd0, 5'd7}; #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_clear got %b exp 1", err); end
    checks++; if (src_pipe !== 2'b00) begin errors++; $display("FAIL clear_pipe got %b exp 00", src_pipe); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_rst got %b exp 0", err); end
  endtask

  task automatic test_reg0();
    iss_valid = 1'b1; iss_wb_en = 1'b1; iss_dst = 5'd0; iss_pipe = 1'b1; src = {5'd0, 5'd0};
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b exp 1", iss_ready); end
    tick(); idle(); #1;
    checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL r0_busy_any got %b exp 0", busy_any); end
    checks++; if (src_busy !== 2'b00) begin errors++; $display("FAIL r0_busy got %b exp 00", src_busy); end
    checks++; if (src_pipe !== 2'b00) begin errors++; $display("FAIL r0_pipe got %b exp 00", src_pipe); end
    wb_valid = 2'b11; wb_dst = {5'd0, 5'd0};
    tick(); idle(); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL r0_wb_err got %b exp 0", err); end
  endtask

  task automatic test_clear();
    issue(5'd1, 1'b0); issue(5'd2, 1'b1); issue(5'd3, 1'b0); issue(5'd4, 1'b1);
    src = {5'd2, 5'd4}; #1;
    checks++; if (busy_any !== 1'b1) begin errors++; $display("FAIL clr_pre got %b exp 1", busy_any); end
    checks++; if (src_busy !== 2'b11) begin errors++; $display("FAIL clr_pre_busy got %b exp 11", src_busy); end
    clear = 1'b1; iss_valid = 1'b1; iss_wb_en = 1'b1; iss_dst = 5'd6; iss_pipe = 1'b1;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL clr_ready got %b exp 1", iss_ready); end
    tick(); idle(); src = {5'd6, 5'd2}; #1;
    checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL clr_busy_any got %b exp 0", busy_any); end
    checks++; if (src_busy !== 2'b00) begin errors++; $display("FAIL clr_busy got %b exp 00", src_busy); end
  endtask

  task automatic test_rst_mid();
    issue(5'd10, 1'b1);
    #1;
    checks++; if (busy_any !== 1'b1) begin errors++; $display("FAIL rm_pre got %b exp 1", busy_any); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL rm_busy_any got %b exp 0", busy_any); end
    wb_valid = 2'b10; wb_dst = {5'd10, 5'd0};
    tick(); idle(); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rm_stray_err got %b exp 1", err); end
  endtask

  initial begin
    rst = 1'b1; idle(); src = '0;
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_issue_wb();
    test_saturate();
    test_same_cycle();
    test_dual_wb();
    test_err();
    test_reg0();
    test_clear();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
